// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver with a configurable frame format.
// The receiver synchronises the line and rejects false starts.
// It reports parity, framing and break errors with each published word.
module uart_rx_cfg #(
  parameter int SYSCLK_F  = 24000000,
  parameter int BAUDRATE  = 500000,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              RX_LINE,
  output logic [DATA_W-1:0] DATA,
  output logic              DATA_RDY_STROBE,
  output logic              PARITY_ERR,
  output logic              FRAME_ERR,
  output logic              BREAK_DET,
  output logic              BUSY
);

  localparam int CYC_PER_BIT = SYSCLK_F / BAUDRATE;
  localparam int HALF        = CYC_PER_BIT / 2;
  localparam int CNT_W       = $clog2(CYC_PER_BIT + 1);
  localparam int IDX_W       = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_PUBLISH, S_WAIT_HI
  } state_t;

  state_t             state_q, state_d;
  logic               rx_m_q, rx_s_q, rx_p_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shr_q, shr_d;
  logic               par_q, par_d;
  logic               facc_q, facc_d;
  logic               zero_q, zero_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;
  logic               brk_q, brk_d;
  logic               bit_tick;

  // Two-flop synchroniser plus one delay stage for falling-edge detection
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_p_q <= 1'b1;
    end else begin
      rx_m_q <= RX_LINE;
      rx_s_q <= rx_m_q;
      rx_p_q <= rx_s_q;
    end
  end

  // State, counters, frame accumulators and published outputs
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shr_q   <= '0;
      par_q   <= 1'b0;
      facc_q  <= 1'b0;
      zero_q  <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shr_q   <= shr_d;
      par_q   <= par_d;
      facc_q  <= facc_d;
      zero_q  <= zero_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      brk_q   <= brk_d;
    end
  end

  assign bit_tick = (cnt_q == CNT_W'(CYC_PER_BIT - 1));

  // Next-state logic: sample at bit centres and publish after the last stop bit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shr_d   = shr_q;
    par_d   = par_q;
    facc_d  = facc_q;
    zero_d  = zero_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    brk_d   = brk_q;
    case (state_q)
      S_IDLE: begin
        if (en && rx_p_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF)) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
            par_d   = 1'b0;
            facc_d  = 1'b0;
            zero_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d  = '0;
          shr_d  = {rx_s_q, shr_q[DATA_W-1:1]};
          par_d  = par_q ^ rx_s_q;
          zero_d = zero_q & ~rx_s_q;
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d   = '0;
          par_d   = par_q ^ rx_s_q;
          zero_d  = zero_q & ~rx_s_q;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d  = '0;
          facc_d = facc_q | ~rx_s_q;
          zero_d = zero_q & ~rx_s_q;
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            // Outputs load on entry so they are valid during the strobe cycle
            state_d = S_PUBLISH;
            idx_d   = '0;
            data_d  = shr_q;
            perr_d  = (PARITY == 1) ? ~par_q : ((PARITY == 2) ? par_q : 1'b0);
            ferr_d  = facc_d;
            brk_d   = zero_d;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PUBLISH: begin
        state_d = ferr_q ? S_WAIT_HI : S_IDLE;
      end
      S_WAIT_HI: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign DATA            = data_q;
  assign PARITY_ERR      = perr_q;
  assign FRAME_ERR       = ferr_q;
  assign BREAK_DET       = brk_q;
  assign DATA_RDY_STROBE = (state_q == S_PUBLISH);
  assign BUSY            = (state_q != S_IDLE);

endmodule
